// File: rtl/rx_initiated_point_test_tx_if.sv
// Sideband wrapper bundle between the D2C point-test initiator and the SB encoder/decoder.
interface rx_initiated_point_test_tx_if #(
    parameter int unsigned SB_MSG_WIDTH = 4
);
    logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg;
    logic                    i_SB_Busy;
    logic                    i_falling_edge_busy;
    logic                    i_rx_valid;
    logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_tx;
    logic                    o_valid_tx;

    // Initiator side: issues requests, observes decoded partner messages.
    modport master (
        input  i_decoded_SB_msg,
        input  i_SB_Busy,
        input  i_falling_edge_busy,
        input  i_rx_valid,
        output o_encoded_SB_msg_tx,
        output o_valid_tx
    );

    // Wrapper side: consumes requests, supplies status and decoded messages.
    modport slave (
        output i_decoded_SB_msg,
        output i_SB_Busy,
        output i_falling_edge_busy,
        output i_rx_valid,
        input  o_encoded_SB_msg_tx,
        input  o_valid_tx
    );
endinterface

// File: rtl/rx_initiated_point_test_tx.sv
// Initiator of the Rx-initiated data-to-clock point test sideband exchange.
module rx_initiated_point_test_tx #(
    parameter int unsigned SB_MSG_WIDTH   = 4,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned PATTERN_CYCLES = 4096,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_tx_d2c_pt_en,
    input  logic                            i_datavref_or_valvref,
    rx_initiated_point_test_tx_if.master    sb,
    output logic [1:0]                      o_mainband_pattern_generator_cw,
    output logic                            o_valid_pattern_en,
    output logic                            o_tx_d2c_pt_done_tx,
    output logic                            o_timeout
);

    localparam logic [SB_MSG_WIDTH-1:0] START_REQ       = SB_MSG_WIDTH'(1);
    localparam logic [SB_MSG_WIDTH-1:0] START_RESP      = SB_MSG_WIDTH'(2);
    localparam logic [SB_MSG_WIDTH-1:0] LFSR_CLR_REQ    = SB_MSG_WIDTH'(3);
    localparam logic [SB_MSG_WIDTH-1:0] LFSR_CLR_RESP   = SB_MSG_WIDTH'(4);
    localparam logic [SB_MSG_WIDTH-1:0] COUNT_DONE_REQ  = SB_MSG_WIDTH'(5);
    localparam logic [SB_MSG_WIDTH-1:0] COUNT_DONE_RESP = SB_MSG_WIDTH'(6);
    localparam logic [SB_MSG_WIDTH-1:0] END_REQ         = SB_MSG_WIDTH'(7);
    localparam logic [SB_MSG_WIDTH-1:0] END_RESP        = SB_MSG_WIDTH'(8);

    localparam logic [CNT_WIDTH-1:0] PAT_LAST = CNT_WIDTH'(PATTERN_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CW_IDLE  = 2'b00;
    localparam logic [1:0] CW_CLEAR = 2'b01;
    localparam logic [1:0] CW_LFSR  = 2'b10;

    localparam logic [3:0] IDLE                 = 4'd0;
    localparam logic [3:0] SEND_START_REQ       = 4'd1;
    localparam logic [3:0] WAIT_START_RESP      = 4'd2;
    localparam logic [3:0] SEND_LFSR_CLR_REQ    = 4'd3;
    localparam logic [3:0] WAIT_LFSR_CLR_RESP   = 4'd4;
    localparam logic [3:0] SEND_PATTERN         = 4'd5;
    localparam logic [3:0] SEND_COUNT_DONE_REQ  = 4'd6;
    localparam logic [3:0] WAIT_COUNT_DONE_RESP = 4'd7;
    localparam logic [3:0] SEND_END_REQ         = 4'd8;
    localparam logic [3:0] WAIT_END_RESP        = 4'd9;
    localparam logic [3:0] TEST_FINISHED        = 4'd10;
    localparam logic [3:0] TIMEOUT              = 4'd11;

    logic [3:0]              state_q;
    logic [3:0]              next_state_c;
    logic [CNT_WIDTH-1:0]    pat_cnt_q;
    logic [CNT_WIDTH-1:0]    tmo_cnt_q;
    logic [SB_MSG_WIDTH-1:0] code_q;
    logic                    valid_q;
    logic                    pending_q;
    logic                    is_wait_c;
    logic [SB_MSG_WIDTH-1:0] exp_resp_c;
    logic                    resp_ok_c;
    logic                    tmo_hit_c;
    logic                    sb_done_c;
    logic                    entering_c;
    logic                    next_is_send_c;

    assign sb.o_encoded_SB_msg_tx = code_q;
    assign sb.o_valid_tx          = valid_q;

    // Expected partner response for the current wait state.
    always_comb begin
        is_wait_c  = 1'b0;
        exp_resp_c = '0;
        case (state_q)
            WAIT_START_RESP:      begin is_wait_c = 1'b1; exp_resp_c = START_RESP;      end
            WAIT_LFSR_CLR_RESP:   begin is_wait_c = 1'b1; exp_resp_c = LFSR_CLR_RESP;   end
            WAIT_COUNT_DONE_RESP: begin is_wait_c = 1'b1; exp_resp_c = COUNT_DONE_RESP; end
            WAIT_END_RESP:        begin is_wait_c = 1'b1; exp_resp_c = END_RESP;        end
            default: ;
        endcase
    end

    assign resp_ok_c  = is_wait_c && (sb.i_decoded_SB_msg == exp_resp_c);
    assign tmo_hit_c  = is_wait_c && (tmo_cnt_q == TMO_LAST);
    assign sb_done_c  = sb.i_falling_edge_busy && !sb.i_rx_valid;
    assign entering_c = (next_state_c != state_q);
    assign next_is_send_c = (next_state_c == SEND_START_REQ)      ||
                            (next_state_c == SEND_LFSR_CLR_REQ)   ||
                            (next_state_c == SEND_COUNT_DONE_REQ) ||
                            (next_state_c == SEND_END_REQ);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= next_state_c;
    end

    // Next-state logic; a dropped enable overrides every other transition.
    always_comb begin
        next_state_c = state_q;
        if (state_q != IDLE && !i_tx_d2c_pt_en) begin
            next_state_c = IDLE;
        end else begin
            case (state_q)
                IDLE:                 if (i_tx_d2c_pt_en) next_state_c = SEND_START_REQ;
                SEND_START_REQ:       if (sb_done_c) next_state_c = WAIT_START_RESP;
                WAIT_START_RESP:      if (resp_ok_c) next_state_c = SEND_LFSR_CLR_REQ;
                                      else if (tmo_hit_c) next_state_c = TIMEOUT;
                SEND_LFSR_CLR_REQ:    if (sb_done_c) next_state_c = WAIT_LFSR_CLR_RESP;
                WAIT_LFSR_CLR_RESP:   if (resp_ok_c) next_state_c = SEND_PATTERN;
                                      else if (tmo_hit_c) next_state_c = TIMEOUT;
                SEND_PATTERN:         if (pat_cnt_q == PAT_LAST) next_state_c = SEND_COUNT_DONE_REQ;
                SEND_COUNT_DONE_REQ:  if (sb_done_c) next_state_c = WAIT_COUNT_DONE_RESP;
                WAIT_COUNT_DONE_RESP: if (resp_ok_c) next_state_c = SEND_END_REQ;
                                      else if (tmo_hit_c) next_state_c = TIMEOUT;
                SEND_END_REQ:         if (sb_done_c) next_state_c = WAIT_END_RESP;
                WAIT_END_RESP:        if (resp_ok_c) next_state_c = TEST_FINISHED;
                                      else if (tmo_hit_c) next_state_c = TIMEOUT;
                TEST_FINISHED:        next_state_c = TEST_FINISHED;
                TIMEOUT:              next_state_c = TIMEOUT;
                default:              next_state_c = IDLE;
            endcase
        end
    end

    // Pattern-burst and response-timeout counters; both restart on any state change.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pat_cnt_q <= '0;
            tmo_cnt_q <= '0;
        end else begin
            pat_cnt_q <= (state_q == SEND_PATTERN && !entering_c) ? pat_cnt_q + 1'b1 : '0;
            tmo_cnt_q <= (is_wait_c && !entering_c) ? tmo_cnt_q + 1'b1 : '0;
        end
    end

    // Registered outputs, updated on the transition edges; IDLE clears everything.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            code_q                          <= '0;
            valid_q                         <= 1'b0;
            pending_q                       <= 1'b0;
            o_mainband_pattern_generator_cw <= CW_IDLE;
            o_valid_pattern_en              <= 1'b0;
            o_tx_d2c_pt_done_tx             <= 1'b0;
            o_timeout                       <= 1'b0;
        end else if (next_state_c == IDLE) begin
            code_q                          <= '0;
            valid_q                         <= 1'b0;
            pending_q                       <= 1'b0;
            o_mainband_pattern_generator_cw <= CW_IDLE;
            o_valid_pattern_en              <= 1'b0;
            o_tx_d2c_pt_done_tx             <= 1'b0;
            o_timeout                       <= 1'b0;
        end else begin
            if (entering_c && state_q == SEND_PATTERN) begin
                o_mainband_pattern_generator_cw <= CW_IDLE;
                o_valid_pattern_en              <= 1'b0;
            end
            if (entering_c) begin
                case (next_state_c)
                    SEND_START_REQ: code_q <= START_REQ;
                    SEND_LFSR_CLR_REQ: begin
                        code_q <= LFSR_CLR_REQ;
                        if (!i_datavref_or_valvref) o_mainband_pattern_generator_cw <= CW_CLEAR;
                    end
                    SEND_PATTERN: begin
                        if (!i_datavref_or_valvref) o_mainband_pattern_generator_cw <= CW_LFSR;
                        else                        o_valid_pattern_en              <= 1'b1;
                    end
                    SEND_COUNT_DONE_REQ: code_q <= COUNT_DONE_REQ;
                    SEND_END_REQ:        code_q <= END_REQ;
                    TEST_FINISHED:       o_tx_d2c_pt_done_tx <= 1'b1;
                    TIMEOUT: begin
                        o_timeout                       <= 1'b1;
                        o_mainband_pattern_generator_cw <= CW_IDLE;
                        o_valid_pattern_en              <= 1'b0;
                    end
                    default: ;
                endcase
            end
            // Valid handshake: immediate when the SB is idle, otherwise deferred.
            if (valid_q) pending_q <= 1'b0;
            if (entering_c && next_is_send_c) begin
                if (!sb.i_SB_Busy) valid_q   <= 1'b1;
                else               pending_q <= 1'b1;
            end else if (pending_q && !sb.i_SB_Busy && !sb.i_rx_valid) begin
                valid_q <= 1'b1;
            end
            if (sb_done_c) valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_initiated_point_test_tx.sv
// Directed bench for the D2C point-test initiator.
module tb_rx_initiated_point_test_tx;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [1:0] cw;
    logic       vpe;
    logic       done;
    logic       tmo;
    int         n_pass;
    int         n_total;

    rx_initiated_point_test_tx_if #(.SB_MSG_WIDTH(4)) sb ();

    rx_initiated_point_test_tx #(
        .SB_MSG_WIDTH   (4),
        .CNT_WIDTH      (16),
        .PATTERN_CYCLES (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_clk                           (clk),
        .i_rst_n                         (rst_n),
        .i_tx_d2c_pt_en                  (en),
        .i_datavref_or_valvref           (mode),
        .sb                              (sb),
        .o_mainband_pattern_generator_cw (cw),
        .o_valid_pattern_en              (vpe),
        .o_tx_d2c_pt_done_tx             (done),
        .o_timeout                       (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for a request, holds it two cycles, then pulses the SB falling edge.
    task automatic send_phase(output logic [3:0] code_o, output bit seen,
                              output bit held, output bit cleared);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (sb.o_valid_tx === 1'b1) seen = 1'b1;
            else step();
        end
        code_o = sb.o_encoded_SB_msg_tx;
        step();
        step();
        held = (sb.o_valid_tx === 1'b1) && (sb.o_encoded_SB_msg_tx === code_o);
        sb.i_falling_edge_busy = 1'b1;
        step();
        sb.i_falling_edge_busy = 1'b0;
        cleared = (sb.o_valid_tx === 1'b0);
    endtask

    // Partner response presented for one cycle, three cycles after the falling-edge pulse.
    task automatic respond(input logic [3:0] resp);
        step();
        step();
        sb.i_decoded_SB_msg = resp;
        step();
        sb.i_decoded_SB_msg = 4'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0; mode = 1'b0;
        sb.i_decoded_SB_msg = 4'd0; sb.i_SB_Busy = 1'b0;
        sb.i_falling_edge_busy = 1'b0; sb.i_rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({sb.o_encoded_SB_msg_tx, sb.o_valid_tx, cw, vpe, done, tmo} !== 10'd0)
            $display("FAIL reset_outputs got=%b exp=0", {sb.o_encoded_SB_msg_tx, sb.o_valid_tx, cw, vpe, done, tmo});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        step(); step();
        n_total++;
        if (sb.o_valid_tx !== 1'b0) $display("FAIL idle_no_enable valid=%b exp=0", sb.o_valid_tx);
        else n_pass++;
    endtask

    // Full exchange; md=0 data lanes, md=1 valid lane.
    task automatic test_nominal(input logic md);
        logic [3:0] code;
        bit seen, held, cleared, cw_bad;
        int n;
        logic [3:0] exp_code [4];
        logic [3:0] resp [4];
        exp_code[0] = 4'd1; exp_code[1] = 4'd3; exp_code[2] = 4'd5; exp_code[3] = 4'd7;
        resp[0] = 4'd2; resp[1] = 4'd4; resp[2] = 4'd6; resp[3] = 4'd8;
        mode = md;
        en = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            send_phase(code, seen, held, cleared);
            n_total++;
            if (!seen || code !== exp_code[k] || !held || !cleared)
                $display("FAIL nominal_md%0d_req%0d code=%0d seen=%0d held=%0d cleared=%0d exp_code=%0d",
                         md, k, code, seen, held, cleared, exp_code[k]);
            else n_pass++;
            respond(resp[k]);
            if (k == 0) begin
                n_total++;
                if (cw !== (md ? 2'b00 : 2'b01)) $display("FAIL nominal_md%0d_cw_clear cw=%b exp=%b", md, cw, md ? 2'b00 : 2'b01);
                else n_pass++;
            end
            if (k == 1) begin
                n = 0; cw_bad = 1'b0;
                while (n < 20 && (md ? (vpe === 1'b1) : (cw === 2'b10))) begin
                    if (md && cw !== 2'b00) cw_bad = 1'b1;
                    if (!md && vpe !== 1'b0) cw_bad = 1'b1;
                    n++;
                    step();
                end
                n_total++;
                if (n != 8 || cw_bad) $display("FAIL nominal_md%0d_pattern_len got=%0d exp=8 side_bad=%0d", md, n, cw_bad);
                else n_pass++;
                n_total++;
                if (cw !== 2'b00 || vpe !== 1'b0) $display("FAIL nominal_md%0d_pattern_off cw=%b vpe=%b exp=00/0", md, cw, vpe);
                else n_pass++;
            end
        end
        n_total++;
        if (done !== 1'b1) $display("FAIL nominal_md%0d_done got=%b exp=1", md, done);
        else n_pass++;
        en = 1'b0;
        step();
        n_total++;
        if (done !== 1'b0 || sb.o_encoded_SB_msg_tx !== 4'd0) $display("FAIL nominal_md%0d_disable done=%b code=%0d exp=0/0", md, done, sb.o_encoded_SB_msg_tx);
        else n_pass++;
    endtask

    task automatic test_busy_defer();
        bit bad;
        mode = 1'b0;
        sb.i_SB_Busy = 1'b1; sb.i_rx_valid = 1'b1;
        en = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (sb.o_valid_tx !== 1'b0) bad = 1'b1;
        end
        n_total++;
        if (bad) $display("FAIL busy_hold valid rose while busy/rx_valid high exp=0");
        else n_pass++;
        sb.i_SB_Busy = 1'b0;
        step();
        n_total++;
        if (sb.o_valid_tx !== 1'b0) $display("FAIL busy_rxvalid_hold valid=%b exp=0", sb.o_valid_tx);
        else n_pass++;
        sb.i_rx_valid = 1'b0;
        n_total++;
        if (sb.o_valid_tx !== 1'b0) $display("FAIL busy_release_same_cycle valid=%b exp=0", sb.o_valid_tx);
        else n_pass++;
        step();
        n_total++;
        if (sb.o_valid_tx !== 1'b1 || sb.o_encoded_SB_msg_tx !== 4'd1)
            $display("FAIL busy_release valid=%b code=%0d exp=1/1", sb.o_valid_tx, sb.o_encoded_SB_msg_tx);
        else n_pass++;
        en = 1'b0;
        step();
    endtask

    task automatic test_wrong_msg();
        logic [3:0] code;
        bit seen, held, cleared;
        mode = 1'b0;
        en = 1'b1;
        step();
        send_phase(code, seen, held, cleared);
        step();
        sb.i_decoded_SB_msg = 4'd6;
        step();
        sb.i_decoded_SB_msg = 4'd0;
        n_total++;
        if (sb.o_encoded_SB_msg_tx !== 4'd1 || sb.o_valid_tx !== 1'b0)
            $display("FAIL wrong_msg_ignored code=%0d valid=%b exp=1/0", sb.o_encoded_SB_msg_tx, sb.o_valid_tx);
        else n_pass++;
        step();
        sb.i_decoded_SB_msg = 4'd2;
        step();
        sb.i_decoded_SB_msg = 4'd0;
        n_total++;
        if (sb.o_encoded_SB_msg_tx !== 4'd3 || sb.o_valid_tx !== 1'b1)
            $display("FAIL wrong_msg_advance code=%0d valid=%b exp=3/1", sb.o_encoded_SB_msg_tx, sb.o_valid_tx);
        else n_pass++;
        en = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        logic [3:0] code;
        bit seen, held, cleared;
        int n;
        mode = 1'b0;
        en = 1'b1;
        step();
        send_phase(code, seen, held, cleared);
        respond(4'd2);
        send_phase(code, seen, held, cleared);
        n = 0;
        while (tmo !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        n_total++;
        if (n != 16) $display("FAIL timeout_cycles got=%0d exp=16", n);
        else n_pass++;
        n_total++;
        if (cw !== 2'b00) $display("FAIL timeout_cw got=%b exp=00", cw);
        else n_pass++;
        step(); step();
        n_total++;
        if (tmo !== 1'b1) $display("FAIL timeout_hold got=%b exp=1", tmo);
        else n_pass++;
        en = 1'b0;
        step();
        n_total++;
        if ({sb.o_encoded_SB_msg_tx, sb.o_valid_tx, cw, vpe, done, tmo} !== 10'd0)
            $display("FAIL timeout_disable got=%b exp=0", {sb.o_encoded_SB_msg_tx, sb.o_valid_tx, cw, vpe, done, tmo});
        else n_pass++;
    endtask

    task automatic test_enable_drop_pattern();
        logic [3:0] code;
        bit seen, held, cleared;
        mode = 1'b0;
        en = 1'b1;
        step();
        send_phase(code, seen, held, cleared);
        respond(4'd2);
        send_phase(code, seen, held, cleared);
        respond(4'd4);
        step(); step(); step();
        n_total++;
        if (cw !== 2'b10) $display("FAIL drop_in_pattern cw=%b exp=10", cw);
        else n_pass++;
        en = 1'b0;
        step();
        n_total++;
        if ({sb.o_encoded_SB_msg_tx, sb.o_valid_tx, cw, vpe, done, tmo} !== 10'd0)
            $display("FAIL drop_cleared got=%b exp=0", {sb.o_encoded_SB_msg_tx, sb.o_valid_tx, cw, vpe, done, tmo});
        else n_pass++;
        en = 1'b1;
        step();
        n_total++;
        if (sb.o_encoded_SB_msg_tx !== 4'd1 || sb.o_valid_tx !== 1'b1)
            $display("FAIL drop_restart code=%0d valid=%b exp=1/1", sb.o_encoded_SB_msg_tx, sb.o_valid_tx);
        else n_pass++;
        en = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        logic [3:0] code;
        bit seen, held, cleared;
        logic [3:0] resp [3];
        resp[0] = 4'd2; resp[1] = 4'd4; resp[2] = 4'd6;
        mode = 1'b1;
        en = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            send_phase(code, seen, held, cleared);
            respond(resp[k]);
        end
        send_phase(code, seen, held, cleared);
        n_total++;
        if (sb.o_encoded_SB_msg_tx !== 4'd7) $display("FAIL rst_pre_code got=%0d exp=7", sb.o_encoded_SB_msg_tx);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({sb.o_encoded_SB_msg_tx, sb.o_valid_tx, cw, vpe, done, tmo} !== 10'd0)
            $display("FAIL async_reset got=%b exp=0", {sb.o_encoded_SB_msg_tx, sb.o_valid_tx, cw, vpe, done, tmo});
        else n_pass++;
        #1 rst_n = 1'b1;
        step();
        n_total++;
        if (sb.o_encoded_SB_msg_tx !== 4'd1 || sb.o_valid_tx !== 1'b1)
            $display("FAIL rst_restart code=%0d valid=%b exp=1/1", sb.o_encoded_SB_msg_tx, sb.o_valid_tx);
        else n_pass++;
        en = 1'b0;
        step();
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_nominal(1'b0);
        test_nominal(1'b1);
        test_busy_defer();
        test_wrong_msg();
        test_timeout();
        test_enable_drop_pattern();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rx_initiated_point_test_tx.md
Name: rx_initiated_point_test_tx

Overview:
- Initiator side of the Rx-initiated data-to-clock point test (D2C PT) sideband exchange.
- Issues the START, LFSR_CLR_ERROR, COUNT_DONE and END requests over the sideband wrapper and waits for each partner response.
- Between the LFSR-clear and count-done handshakes it drives the local mainband pattern generator (data lanes) or the valid-lane pattern for a fixed burst length.
- Sits under the LTSM next to the responder on the same sideband wrapper, and reports done or timeout to the LTSM.

Parameters:
- SB_MSG_WIDTH, 4, width of encoded/decoded sideband message codes.
- CNT_WIDTH, 16, width of the pattern-burst and timeout counters.
- PATTERN_CYCLES, 4096, number of i_clk cycles the pattern is driven (1..2^CNT_WIDTH-1).
- TIMEOUT_CYCLES, 65535, maximum cycles spent in any WAIT_* state before abort.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_tx_d2c_pt_en  in  1  LTSM enable; low forces IDLE.
- i_datavref_or_valvref  in  1  0: data lanes, 1: valid lane.
- i_decoded_SB_msg  in  SB_MSG_WIDTH  decoded partner message.
- i_SB_Busy  in  1  sideband transmitter busy.
- i_falling_edge_busy  in  1  one-cycle pulse when the SB finishes a transfer.
- i_rx_valid  in  1  responder's valid on the shared wrapper.
- o_encoded_SB_msg_tx  out  SB_MSG_WIDTH  request code to the SB encoder.
- o_valid_tx  out  1  request valid to the wrapper.
- o_mainband_pattern_generator_cw  out  2  generator control: 00 IDLE, 01 CLEAR_LFSR, 10 LFSR, 11 NOP (never driven).
- o_valid_pattern_en  out  1  enables the valid-lane pattern.
- o_tx_d2c_pt_done_tx  out  1  test completed.
- o_timeout  out  1  response timeout occurred.

Behaviour:
- All outputs reset to 0. State register and both counters reset to 0 / IDLE.
- Message codes:
  - START_REQ=1, START_RESP=2
  - LFSR_CLR_REQ=3, LFSR_CLR_RESP=4
  - COUNT_DONE_REQ=5, COUNT_DONE_RESP=6
  - END_REQ=7, END_RESP=8
- States: IDLE, SEND_START_REQ, WAIT_START_RESP, SEND_LFSR_CLR_REQ, WAIT_LFSR_CLR_RESP, SEND_PATTERN, SEND_COUNT_DONE_REQ, WAIT_COUNT_DONE_RESP, SEND_END_REQ, WAIT_END_RESP, TEST_FINISHED, TIMEOUT.
- Enable handling:
  - IDLE -> SEND_START_REQ when enable is high.
  - In every non-IDLE state, enable low -> IDLE next cycle; this has priority over all other transitions.
- SEND_* -> matching WAIT_* on (i_falling_edge_busy && !i_rx_valid).
- WAIT_* -> next state when i_decoded_SB_msg equals the expected response:
  - WAIT_START_RESP -> SEND_LFSR_CLR_REQ
  - WAIT_LFSR_CLR_RESP -> SEND_PATTERN
  - WAIT_COUNT_DONE_RESP -> SEND_END_REQ
  - WAIT_END_RESP -> TEST_FINISHED
  - Any other message is ignored.
- SEND_PATTERN:
  - Counter loads 0 on entry and increments each cycle.
  - -> SEND_COUNT_DONE_REQ when the counter reaches PATTERN_CYCLES-1, so the state lasts exactly PATTERN_CYCLES cycles.
- Timeout:
  - The timeout counter clears on every state change and counts only in WAIT_* states.
  - When it reaches TIMEOUT_CYCLES-1 and the expected response is not present that cycle -> TIMEOUT.
  - A response arriving in the same cycle wins.
- TEST_FINISHED and TIMEOUT hold until enable drops.
- Registered outputs; each updates on the clock edge of the transition named:
  - On entering any SEND_*_REQ: o_encoded_SB_msg_tx <= that request code.
  - On entering SEND_LFSR_CLR_REQ with data mode: cw <= 01.
  - On entering SEND_PATTERN: data mode -> cw <= 10; valid mode -> o_valid_pattern_en <= 1.
  - On leaving SEND_PATTERN: cw <= 00, o_valid_pattern_en <= 0.
  - On entering TEST_FINISHED: done <= 1.
  - On entering TIMEOUT: o_timeout <= 1, cw <= 00, o_valid_pattern_en <= 0.
  - While in IDLE: all outputs, the pending flag and the counters are cleared.
- Valid handshake:
  - When entering SEND_*: if !i_SB_Busy, set o_valid_tx next cycle; else set the pending flag.
  - While the pending flag is set, o_valid_tx sets on the first cycle with !i_SB_Busy && !i_rx_valid; the pending flag clears once o_valid_tx is 1.
  - o_valid_tx clears on (i_falling_edge_busy && !i_rx_valid); the clear has priority over the set.
  - The message code is stable for as long as o_valid_tx is high.
- Reset mid-operation (async): everything returns to reset values immediately.

Test Plan:
- Nominal data mode, PATTERN_CYCLES=8, no busy:
  - Responses 2, 4, 6, 8 each arrive 3 cycles after the falling_edge pulse.
  - Required: codes 1, 3, 5, 7 on o_encoded_SB_msg_tx, each with one valid pulse ending on falling_edge.
  - Required: cw 01 -> 10 for exactly 8 cycles -> 00; done=1.
- Valid mode, same sequence:
  - Required: cw stays 00; o_valid_pattern_en=1 for exactly 8 cycles; done=1.
- i_SB_Busy=1 and i_rx_valid=1 at START entry, both released after 5 cycles:
  - Required: o_valid_tx stays 0 while either is high, then rises the cycle after release, with code 1.
- Wrong message 6 while in WAIT_START_RESP, then 2:
  - Required: the 6 is ignored; the machine advances only on 2.
- TIMEOUT_CYCLES=16, no response in WAIT_LFSR_CLR_RESP:
  - Required: o_timeout=1 after 16 cycles and cw=00; enable low -> all outputs 0.
- Enable dropped mid SEND_PATTERN (count 3), or async reset asserted in WAIT_END_RESP:
  - Required: IDLE next cycle (enable case) or immediately (reset case); outputs cleared; a subsequent enable restarts with code 1.
